// File: rtl/onchip_arb_pkg.sv
// Shared definitions for the on-chip RAM port arbiter.
//   ARB_ADDR_W / ARB_DATA_W : default word-address and data widths
//   ARB_BE_W                : byte-enable width for the default data width
//   arb_state_e             : bus-lock FSM states (used only with ARB_LOCK_EN)
package onchip_arb_pkg;
  localparam int ARB_ADDR_W = 15;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this cycle
//   grant : one-hot grant
//   idx   : index of the granted requester
//   vld   : any grant issued
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);
  // One spare bit so ptr+offset can be wrapped for non-power-of-2 N.
  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!vld && req[cand[IDX_W-1:0]]) begin
        vld                     = 1'b1;
        idx                     = cand[IDX_W-1:0];
        grant[cand[IDX_W-1:0]]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/onchip_mem_port_arbiter.sv
// Shares one Avalon-MM port of an on-chip RAM between NUM_MASTERS data
// masters. One access is granted per cycle in round-robin order; a granted
// access completes in the same cycle, reads return exactly one cycle later.
// Optional macro ARB_LOCK_EN adds m_lock and a bus-lock FSM so one master can
// hold the port across a read-modify-write sequence.
// Ports:
//   clk, reset_n                    : clock, async active-low reset
//   m_lock (ARB_LOCK_EN only)       : per-master lock request
//   m_address/byteenable/writedata  : packed per-master request fields
//   m_read, m_write                 : per-master commands (both set = write)
//   m_waitrequest                   : per-master stall
//   m_readdata, m_readdatavalid     : broadcast read data, per-master strobe
//   mem_*                           : RAM port (mem_clken tied high)
module onchip_mem_port_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int DATA_W      = ARB_DATA_W,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                               clk,
  input  logic                               reset_n,
`ifdef ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]             m_lock,
`endif
  input  logic [NUM_MASTERS*ADDR_W-1:0]      m_address,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]  m_byteenable,
  input  logic [NUM_MASTERS-1:0]             m_read,
  input  logic [NUM_MASTERS-1:0]             m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]      m_writedata,
  output logic [NUM_MASTERS-1:0]             m_waitrequest,
  output logic [DATA_W-1:0]                  m_readdata,
  output logic [NUM_MASTERS-1:0]             m_readdatavalid,
  output logic [ADDR_W-1:0]                  mem_address,
  output logic [DATA_W/8-1:0]                mem_byteenable,
  output logic                               mem_chipselect,
  output logic                               mem_write,
  output logic [DATA_W-1:0]                  mem_writedata,
  output logic                               mem_clken,
  input  logic [DATA_W-1:0]                  mem_readdata
);
  localparam int BE_W = DATA_W / 8;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } lane_req_t;

  lane_req_t [NUM_MASTERS-1:0] lane_req;
  lane_req_t                   sel;
  logic [NUM_MASTERS-1:0]      req, arb_req, gnt;
  logic [IDX_W-1:0]            rr_ptr, gnt_idx, rd_idx;
  logic                        gnt_vld, ptr_adv, rd_pend;

  assign req = m_read | m_write;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    assign lane_req[i].write = m_write[i];
    assign lane_req[i].addr  = m_address[i*ADDR_W +: ADDR_W];
    assign lane_req[i].be    = m_byteenable[i*BE_W +: BE_W];
    assign lane_req[i].wdata = m_writedata[i*DATA_W +: DATA_W];
    assign m_waitrequest[i]   = req[i] & ~gnt[i];
    assign m_readdatavalid[i] = rd_pend & (rd_idx == IDX_W'(i));
  end

  rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .vld   (gnt_vld)
  );

`ifdef ARB_LOCK_EN
  arb_state_e       lock_state;
  logic [IDX_W-1:0] lock_idx;

  // While locked only the owner may reach the RAM; others keep stalling.
  always_comb begin
    arb_req = req;
    if (lock_state == ARB_LOCKED)
      for (int i = 0; i < NUM_MASTERS; i++)
        arb_req[i] = req[i] & (IDX_W'(i) == lock_idx);
  end

  // Locked grants do not move the pointer, so the owner's access doesn't
  // cost anyone their round-robin turn.
  assign ptr_adv = gnt_vld & (lock_state == ARB_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_state <= ARB_IDLE;
      lock_idx   <= '0;
    end else begin
      case (lock_state)
        ARB_IDLE:   if (gnt_vld && m_lock[gnt_idx]) begin
                      lock_state <= ARB_LOCKED;
                      lock_idx   <= gnt_idx;
                    end
        ARB_LOCKED: if (!m_lock[lock_idx]) lock_state <= ARB_IDLE;
        default:    lock_state <= ARB_IDLE;
      endcase
    end
  end
`else
  assign arb_req = req;
  assign ptr_adv = gnt_vld;
`endif

  assign sel       = lane_req[gnt_idx];
  assign mem_clken = 1'b1;

  always_comb begin
    mem_chipselect = gnt_vld;
    mem_write      = gnt_vld & sel.write;
    mem_address    = gnt_vld ? sel.addr  : '0;
    mem_byteenable = gnt_vld ? sel.be    : '0;
    mem_writedata  = gnt_vld ? sel.wdata : '0;
  end

  // RAM q is valid the cycle after the read, so it is passed straight through.
  assign m_readdata = mem_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr  <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
    end else begin
      if (ptr_adv)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : gnt_idx + 1'b1;
      rd_pend <= gnt_vld & ~sel.write;
      rd_idx  <= gnt_idx;
    end
  end

  // Read+write together is a master bug; it is served as a write.
  assert property (@(posedge clk) disable iff (!reset_n) (m_read & m_write) == '0);
endmodule

// File: tb/tb_onchip_mem_port_arbiter.sv
module tb_onchip_mem_port_arbiter;
  localparam int N = 4, AW = 15, DW = 32, BW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][BW-1:0] be;
  logic [N-1:0][DW-1:0] wd;
  logic [N-1:0]         rd, wr;
`ifdef ARB_LOCK_EN
  logic [N-1:0]         lk;
`endif

  logic [N-1:0]  m_waitrequest, m_readdatavalid;
  logic [DW-1:0] m_readdata, mem_writedata, mem_readdata;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;

  onchip_mem_port_arbiter #(.NUM_MASTERS(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
`ifdef ARB_LOCK_EN
    .m_lock          (lk),
`endif
    .m_address       (addr),
    .m_byteenable    (be),
    .m_read          (rd),
    .m_write         (wr),
    .m_writedata     (wd),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
  );

  // RAM port: registered q, byte-masked writes.
  logic [DW-1:0] ram [0:32767];
  initial begin
    for (int a = 0; a < 32768; a++) ram[a] = 32'(a) * 32'h9E3779B1;
    ram[16]    = 32'hDEADBEEF;
    ram[16'h200] = 32'h0;
    mem_readdata = '0;
    forever begin
      @(posedge clk);
      if (mem_chipselect && mem_clken) begin
        if (mem_write) begin
          for (int b = 0; b < BW; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end else mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model: memory contents, rotating priority, lock owner.
  logic [DW-1:0] ref_mem [0:32767];
  int ptr, lock_owner, exp_rd, g_cur;
  logic [DW-1:0] exp_rd_data;
  int n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] lock_mask();
`ifdef ARB_LOCK_EN
    return lk;
`else
    return '0;
`endif
  endfunction

  function automatic int model_grant();
    for (int d = 0; d < N; d++) begin
      int m;
      m = (ptr + d) % N;
      if ((rd[m] || wr[m]) && (lock_owner < 0 || m == lock_owner)) return m;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr = 0; lock_owner = -1; exp_rd = -1; g_cur = -1;
  endtask

  // Compare all outputs against the model; call mid-cycle.
  task automatic chk_now();
    logic [N-1:0] w;
    int g;
    @(negedge clk);
    g = model_grant();
    g_cur = g;
    for (int i = 0; i < N; i++) w[i] = (rd[i] | wr[i]) && (i != g);
    chk("waitrequest", 64'(m_waitrequest), 64'(w));
    chk("chipselect", 64'(mem_chipselect), 64'(g >= 0));
    chk("mem_write", 64'(mem_write), (g >= 0) ? 64'(wr[g]) : 64'd0);
    chk("mem_address", 64'(mem_address), (g >= 0) ? 64'(addr[g]) : 64'd0);
    chk("mem_byteenable", 64'(mem_byteenable), (g >= 0) ? 64'(be[g]) : 64'd0);
    chk("mem_writedata", 64'(mem_writedata), (g >= 0) ? 64'(wd[g]) : 64'd0);
    chk("mem_clken", 64'(mem_clken), 64'd1);
    chk("readdatavalid", 64'(m_readdatavalid), (exp_rd >= 0) ? (64'd1 << exp_rd) : 64'd0);
    if (exp_rd >= 0) chk("readdata", 64'(m_readdata), 64'(exp_rd_data));
  endtask

  // Advance one clock and update the model with the access granted this cycle.
  task automatic adv();
    int g;
    logic [N-1:0] lm;
    @(posedge clk);
    g = g_cur;
    lm = lock_mask();
    exp_rd = -1;
    if (g >= 0) begin
      if (wr[g]) begin
        for (int b = 0; b < BW; b++)
          if (be[g][b]) ref_mem[addr[g]][8*b +: 8] = wd[g][8*b +: 8];
      end else begin
        exp_rd = g;
        exp_rd_data = ref_mem[addr[g]];
      end
      if (lock_owner < 0) ptr = (g + 1) % N;
    end
    if (lock_owner < 0) begin
      if (g >= 0 && lm[g]) lock_owner = g;
    end else if (!lm[lock_owner]) lock_owner = -1;
    #1;
  endtask

  task automatic cyc();
    chk_now();
    adv();
  endtask

  task automatic clr();
    rd = '0; wr = '0; addr = '0; be = '0; wd = '0;
`ifdef ARB_LOCK_EN
    lk = '0;
`endif
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp_wait;
    int           exp_gnt;
  } vec_t;
  vec_t vt [8];

  int prev, gi;

  initial begin
    // Hand-derived grants, starting from pointer 1 (after the single read).
    vt[0] = '{4'b1111, 4'b1101,  1};
    vt[1] = '{4'b0011, 4'b0010,  0};
    vt[2] = '{4'b1000, 4'b0000,  3};
    vt[3] = '{4'b0000, 4'b0000, -1};
    vt[4] = '{4'b0110, 4'b0100,  1};
    vt[5] = '{4'b0110, 4'b0010,  2};
    vt[6] = '{4'b0101, 4'b0100,  0};
    vt[7] = '{4'b1001, 4'b0001,  3};

    for (int a = 0; a < 32768; a++) ref_mem[a] = 32'(a) * 32'h9E3779B1;
    ref_mem[16]     = 32'hDEADBEEF;
    ref_mem[16'h200] = 32'h0;

    clr();
    reset_n = 1'b0;
    model_reset();
    adv(); adv();
    chk_now();
    chk("reset_rdv", 64'(m_readdatavalid), 64'd0);
    chk("reset_cs", 64'(mem_chipselect), 64'd0);
    adv();
    reset_n = 1'b1;
    cyc();

    // Single read
    rd[0] = 1'b1; addr[0] = 15'h10; be[0] = 4'hF;
    chk_now();
    chk("single_rd_wait", 64'(m_waitrequest[0]), 64'd0);
    adv();
    clr();
    chk_now();
    chk("single_rd_rdv", 64'(m_readdatavalid), 64'b0001);
    chk("single_rd_data", 64'(m_readdata), 64'hDEADBEEF);
    adv();

    // Table-driven arbitration vectors
    for (int v = 0; v < 8; v++) begin
      clr();
      rd = vt[v].req;
      for (int i = 0; i < N; i++) begin addr[i] = 15'(16'h20 + i); be[i] = 4'hF; end
      chk_now();
      chk("vec_wait", 64'(m_waitrequest), 64'(vt[v].exp_wait));
      chk("vec_addr", 64'(mem_address), (vt[v].exp_gnt >= 0) ? 64'(16'h20 + vt[v].exp_gnt) : 64'd0);
      adv();
    end

    // Simultaneous reads from all masters with pointer at 0
    clr();
    rd = '1;
    for (int i = 0; i < N; i++) begin addr[i] = 15'(16'h30 + i); be[i] = 4'hF; end
    for (int k = 0; k < N; k++) begin
      chk_now();
      chk("simul_grant", 64'(~m_waitrequest & rd), 64'd1 << k);
      if (k > 0) chk("simul_rdv", 64'(m_readdatavalid), 64'd1 << (k - 1));
      adv();
      rd[k] = 1'b0;
    end
    chk_now();
    chk("simul_rdv_last", 64'(m_readdatavalid), 64'b1000);
    adv();
    rd = '1;
    chk_now();
    chk("ptr_wrapped", 64'(m_waitrequest), 64'b1110);
    adv();

    // Byte write then immediate read-back of the same word
    clr();
    wr[2] = 1'b1; addr[2] = 15'h200; wd[2] = 32'h11223344; be[2] = 4'b0100;
    cyc();
    wr[2] = 1'b0; rd[2] = 1'b1; be[2] = 4'hF;
    cyc();
    clr();
    chk_now();
    chk("byte_wr_rdv", 64'(m_readdatavalid), 64'b0100);
    chk("byte_wr_data", 64'(m_readdata), 64'h00220000);
    adv();

    // Two masters requesting continuously must alternate
    clr();
    rd[0] = 1'b1; rd[1] = 1'b1; addr[0] = 15'h40; addr[1] = 15'h41; be[0] = 4'hF; be[1] = 4'hF;
    prev = -1;
    for (int c = 0; c < 20; c++) begin
      chk_now();
      chk("starve_one_stall", 64'(m_waitrequest[0] ^ m_waitrequest[1]), 64'd1);
      gi = m_waitrequest[0] ? 1 : 0;
      if (prev >= 0) chk("starve_alternate", 64'(gi), 64'(1 - prev));
      prev = gi;
      adv();
    end

    // Reset in the cycle after a read grant drops the read
    clr();
    rd[1] = 1'b1; addr[1] = 15'h10; be[1] = 4'hF;
    cyc();
    reset_n = 1'b0;
    model_reset();
    clr();
    chk_now();
    chk("rst_mid_rdv", 64'(m_readdatavalid), 64'd0);
    adv();
    reset_n = 1'b1;
    rd = 4'b1100; addr[2] = 15'h12; addr[3] = 15'h13; be[2] = 4'hF; be[3] = 4'hF;
    chk_now();
    chk("rst_first_grant", 64'(m_waitrequest), 64'b1000);
    adv();
    clr();
    cyc();

`ifdef ARB_LOCK_EN
    // Locked read-modify-write by master 1 while master 3 waits
    reset_n = 1'b0;
    model_reset();
    adv();
    reset_n = 1'b1;
    clr();
    rd[1] = 1'b1; lk[1] = 1'b1; addr[1] = 15'h100; be[1] = 4'hF;
    rd[3] = 1'b1; addr[3] = 15'h104; be[3] = 4'hF;
    chk_now(); chk("lock_c1", 64'(m_waitrequest), 64'b1000); adv();
    rd[1] = 1'b0; wr[1] = 1'b1; wd[1] = 32'hCAFE0001;
    chk_now(); chk("lock_c2", 64'(m_waitrequest), 64'b1000); adv();
    wr[1] = 1'b0;
    chk_now(); chk("lock_c3", 64'(m_waitrequest), 64'b1000); adv();
    lk[1] = 1'b0;
    chk_now(); chk("lock_c4", 64'(m_waitrequest), 64'b1000); adv();
    chk_now(); chk("lock_c5", 64'(m_waitrequest), 64'b0000); adv();
    clr();
    cyc();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 3);
        rd[i] = (r == 1 || r == 2);
        wr[i] = (r == 3);
        addr[i] = 15'($urandom_range(0, 7));
        be[i] = 4'($urandom_range(1, 15));
        wd[i] = $urandom;
`ifdef ARB_LOCK_EN
        lk[i] = ($urandom_range(0, 7) == 0);
`endif
      end
      cyc();
    end
    clr();
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
